// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 RGB565 byte-stream capture, packed to RGB444 and written into frame-buffer BRAM.
// Optional per-frame line counter output LINE_CNT_O enabled by defining CAPTURE_LINE_CNT_EN.
module ov7670_capture #(
   parameter int MAX_ADDRESS_C = 30720,
   parameter int ADDR_W_C      = 16
) (
   input  logic                PCLK_I,
   input  logic                RST_I,
   input  logic                ENABLE_I,
   input  logic                CAM_VSYNC_I,
   input  logic                CAM_HREF_I,
   input  logic [7:0]          CAM_DATA_I,
   output logic                BRAM_WE_O,
   output logic [ADDR_W_C-1:0] BRAM_ADDR_O,
   output logic [11:0]         BRAM_DATA_O,
   output logic                FRAME_DONE_O,
`ifdef CAPTURE_LINE_CNT_EN
   output logic [9:0]          LINE_CNT_O,
`endif
   output logic                BUSY_O
);

   localparam logic [1:0] IDLE_S       = 2'd0;
   localparam logic [1:0] WAIT_FRAME_S = 2'd1;
   localparam logic [1:0] CAPTURE_S    = 2'd2;

   localparam logic [ADDR_W_C-1:0] MAX_ADDR_L = ADDR_W_C'(MAX_ADDRESS_C);
   localparam logic [ADDR_W_C-1:0] ADDR_ONE_L = ADDR_W_C'(1);

   logic                vsync_q;
   logic                vsync_prev_q;
   logic                href_q;
   logic [7:0]          data_q;
   logic                enable_prev_q;

   logic [1:0]          state_q, state_d;
   logic                phase_q, phase_d;
   logic [6:0]          b0_q, b0_d;
   logic [ADDR_W_C-1:0] addr_q, addr_d;
   logic                we_q, we_d;
   logic [11:0]         wdata_q, wdata_d;
   logic                done_q, done_d;

   logic                vsync_rise;
   logic                vsync_fall;
   logic                enable_rise;
   logic                addr_full;
   logic                frame_start;

   always_ff @(posedge PCLK_I) begin
      if (RST_I) begin
         vsync_q       <= 1'b0;
         vsync_prev_q  <= 1'b0;
         href_q        <= 1'b0;
         data_q        <= 8'd0;
         // Reset as if ENABLE were already high so a level held through reset is not taken as an edge.
         enable_prev_q <= 1'b1;
      end else begin
         vsync_q       <= CAM_VSYNC_I;
         vsync_prev_q  <= vsync_q;
         href_q        <= CAM_HREF_I;
         data_q        <= CAM_DATA_I;
         enable_prev_q <= ENABLE_I;
      end
   end

   assign vsync_rise  = vsync_q & ~vsync_prev_q;
   assign vsync_fall  = ~vsync_q & vsync_prev_q;
   assign enable_rise = ENABLE_I & ~enable_prev_q;
   assign addr_full   = (addr_q == MAX_ADDR_L);
   assign frame_start = (state_q == WAIT_FRAME_S) && ENABLE_I && vsync_fall;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      b0_d    = b0_q;
      addr_d  = addr_q;
      we_d    = 1'b0;
      wdata_d = wdata_q;
      done_d  = 1'b0;

      // The address advances in the cycle after each write strobe.
      if (we_q) begin
         addr_d = addr_q + ADDR_ONE_L;
      end

      case (state_q)
         IDLE_S: begin
            if (enable_rise) begin
               state_d = WAIT_FRAME_S;
            end
         end
         WAIT_FRAME_S: begin
            if (!ENABLE_I) begin
               state_d = IDLE_S;
            end else if (frame_start) begin
               state_d = CAPTURE_S;
               addr_d  = '0;
               phase_d = 1'b0;
            end
         end
         CAPTURE_S: begin
            if (href_q) begin
               phase_d = ~phase_q;
               if (!phase_q) begin
                  b0_d = {data_q[7:4], data_q[2:0]};
               end else if (!addr_full) begin
                  we_d    = 1'b1;
                  wdata_d = {b0_q[6:3], b0_q[2:0], data_q[7], data_q[4:1]};
               end
            end else begin
               phase_d = 1'b0;
            end
            if (vsync_rise) begin
               done_d  = 1'b1;
               state_d = ENABLE_I ? WAIT_FRAME_S : IDLE_S;
            end
         end
         default: begin
            state_d = IDLE_S;
         end
      endcase
   end

   always_ff @(posedge PCLK_I) begin
      if (RST_I) begin
         state_q <= IDLE_S;
         phase_q <= 1'b0;
         b0_q    <= 7'd0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= 12'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         b0_q    <= b0_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
      end
   end

   assign BRAM_WE_O    = we_q;
   assign BRAM_ADDR_O  = addr_q;
   assign BRAM_DATA_O  = wdata_q;
   assign FRAME_DONE_O = done_q;
   assign BUSY_O       = (state_q != IDLE_S);

`ifdef CAPTURE_LINE_CNT_EN
   logic       href_prev_q;
   logic       line_pix_q, line_pix_d;
   logic [9:0] line_cnt_q, line_cnt_d;
   logic       href_fall;

   assign href_fall = href_prev_q & ~href_q;

   // A line counts only if it delivered at least one complete byte pair.
   always_comb begin
      line_cnt_d = line_cnt_q;
      line_pix_d = line_pix_q;
      if (frame_start) begin
         line_cnt_d = 10'd0;
         line_pix_d = 1'b0;
      end else if (state_q == CAPTURE_S) begin
         if (href_q && phase_q) begin
            line_pix_d = 1'b1;
         end
         if (href_fall) begin
            line_pix_d = 1'b0;
            if (line_pix_q && (line_cnt_q != 10'd1023)) begin
               line_cnt_d = line_cnt_q + 10'd1;
            end
         end
      end
   end

   always_ff @(posedge PCLK_I) begin
      if (RST_I) begin
         href_prev_q <= 1'b0;
         line_pix_q  <= 1'b0;
         line_cnt_q  <= 10'd0;
      end else begin
         href_prev_q <= href_q;
         line_pix_q  <= line_pix_d;
         line_cnt_q  <= line_cnt_d;
      end
   end

   assign LINE_CNT_O = line_cnt_q;
`else
   // Line counting is compiled out; HREF edges are not tracked.
`endif

endmodule

// File: tb/tb_ov7670_capture.sv
// tb/tb_ov7670_capture.sv - self-checking bench for ov7670_capture against a frame-level byte-pair model.
module tb_ov7670_capture;

   localparam int MAX = 30720;

   typedef logic [7:0] byte_q_t [$];

   logic        clk;
   logic        RST_I;
   logic        ENABLE_I;
   logic        CAM_VSYNC_I;
   logic        CAM_HREF_I;
   logic [7:0]  CAM_DATA_I;
   logic        BRAM_WE_O;
   logic [15:0] BRAM_ADDR_O;
   logic [11:0] BRAM_DATA_O;
   logic        FRAME_DONE_O;
   logic        BUSY_O;
`ifdef CAPTURE_LINE_CNT_EN
   logic [9:0]  LINE_CNT_O;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   logic [27:0] act_q [$];
   logic [27:0] exp_q [$];
   int          done_cnt = 0;
   int          cyc = 0;
   int          last_we_cyc = -1;
   int          last_done_cyc = -2;
   int          pix_idx = 0;
   int          lines_exp = 0;

   ov7670_capture #(.MAX_ADDRESS_C(MAX), .ADDR_W_C(16)) dut (
      .PCLK_I       (clk),
      .RST_I        (RST_I),
      .ENABLE_I     (ENABLE_I),
      .CAM_VSYNC_I  (CAM_VSYNC_I),
      .CAM_HREF_I   (CAM_HREF_I),
      .CAM_DATA_I   (CAM_DATA_I),
      .BRAM_WE_O    (BRAM_WE_O),
      .BRAM_ADDR_O  (BRAM_ADDR_O),
      .BRAM_DATA_O  (BRAM_DATA_O),
      .FRAME_DONE_O (FRAME_DONE_O),
`ifdef CAPTURE_LINE_CNT_EN
      .LINE_CNT_O   (LINE_CNT_O),
`endif
      .BUSY_O       (BUSY_O)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (BRAM_WE_O) begin
         act_q.push_back({BRAM_ADDR_O, BRAM_DATA_O});
         last_we_cyc = cyc;
      end
      if (FRAME_DONE_O) begin
         done_cnt++;
         last_done_cyc = cyc;
      end
   end

   // RGB565 byte pair reduced to 4-bit R, G, B by plain arithmetic.
   function automatic logic [11:0] pack_pix(input logic [7:0] b0, input logic [7:0] b1);
      int r, g, b;
      r = int'(b0) / 16;
      g = (int'(b0) % 8) * 2 + int'(b1) / 128;
      b = (int'(b1) / 2) % 16;
      return 12'(r * 256 + g * 16 + b);
   endfunction

   function automatic byte_q_t rand_bytes(input int n);
      byte_q_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   task automatic model_line(input byte_q_t b);
      for (int i = 0; i + 1 < b.size(); i += 2) begin
         if (pix_idx < MAX) exp_q.push_back({16'(pix_idx), pack_pix(b[i], b[i+1])});
         pix_idx++;
      end
      if (b.size() >= 2) lines_exp++;
   endtask

   task automatic clear_capture();
      act_q.delete();
      exp_q.delete();
      done_cnt = 0;
   endtask

   task automatic frame_begin(input bit model_on);
      @(negedge clk) CAM_VSYNC_I = 1'b1;
      repeat (3) @(negedge clk);
      CAM_VSYNC_I = 1'b0;
      repeat (4) @(negedge clk);
      if (model_on) begin
         pix_idx   = 0;
         lines_exp = 0;
      end
   endtask

   task automatic frame_end();
      @(negedge clk) CAM_VSYNC_I = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic send_line(input byte_q_t b, input bit model_on);
      for (int i = 0; i < b.size(); i++) begin
         @(negedge clk);
         CAM_HREF_I = 1'b1;
         CAM_DATA_I = b[i];
      end
      @(negedge clk);
      CAM_HREF_I = 1'b0;
      CAM_DATA_I = 8'($urandom);
      repeat (3) @(negedge clk);
      if (model_on) model_line(b);
   endtask

   task automatic test_reset();
      RST_I = 1'b1; ENABLE_I = 1'b1; CAM_VSYNC_I = 1'b0; CAM_HREF_I = 1'b0; CAM_DATA_I = 8'h00;
      repeat (5) @(negedge clk) CAM_DATA_I = 8'($urandom);
      n_assert += 5;
      if (BRAM_WE_O !== 1'b0)     begin n_fail++; $display("FAIL reset_we: got %b expected 0", BRAM_WE_O); end
      if (BRAM_ADDR_O !== 16'd0)  begin n_fail++; $display("FAIL reset_addr: got %h expected 0", BRAM_ADDR_O); end
      if (BRAM_DATA_O !== 12'd0)  begin n_fail++; $display("FAIL reset_data: got %h expected 0", BRAM_DATA_O); end
      if (FRAME_DONE_O !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b expected 0", FRAME_DONE_O); end
      if (BUSY_O !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b expected 0", BUSY_O); end
      RST_I = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_enable_held();
      clear_capture();
      frame_begin(0);
      send_line(rand_bytes(4), 0);
      frame_end();
      n_assert += 3;
      if (act_q.size() != 0) begin n_fail++; $display("FAIL held_writes: got %0d expected 0", act_q.size()); end
      if (done_cnt != 0)     begin n_fail++; $display("FAIL held_done: got %0d expected 0", done_cnt); end
      if (BUSY_O !== 1'b0)   begin n_fail++; $display("FAIL held_busy: got %b expected 0", BUSY_O); end
      // Re-arm in the middle of a frame: capture must wait for the next VSYNC fall.
      frame_begin(0);
      ENABLE_I = 1'b0;
      send_line(rand_bytes(4), 0);
      ENABLE_I = 1'b1;
      send_line(rand_bytes(6), 0);
      n_assert++;
      if (BUSY_O !== 1'b1) begin n_fail++; $display("FAIL midedge_busy: got %b expected 1", BUSY_O); end
      frame_end();
      n_assert += 2;
      if (act_q.size() != 0) begin n_fail++; $display("FAIL midedge_writes: got %0d expected 0", act_q.size()); end
      if (done_cnt != 0)     begin n_fail++; $display("FAIL midedge_done: got %0d expected 0", done_cnt); end
      clear_capture();
      frame_begin(1);
      send_line(rand_bytes(6), 1);
      frame_end();
      n_assert += 2;
      if (done_cnt != 1) begin n_fail++; $display("FAIL armed_done: got %0d expected 1", done_cnt); end
      if (act_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL armed_count: got %0d expected %0d", act_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         n_assert++;
         if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL armed_write[%0d]: got %h expected %h", i, act_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_basic();
      byte_q_t b;
      b = '{8'hF8, 8'h1F, 8'h07, 8'hE0};
      clear_capture();
      frame_begin(1);
      n_assert++;
      if (BUSY_O !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", BUSY_O); end
      send_line(b, 1);
      frame_end();
      n_assert += 2;
      if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done: got %0d expected 1", done_cnt); end
      if (act_q.size() != 2) begin
         n_fail++; $display("FAIL basic_count: got %0d expected 2", act_q.size());
      end else begin
         n_assert += 2;
         if (act_q[0] !== {16'd0, 12'hF0F}) begin n_fail++; $display("FAIL basic_pix0: got %h expected %h", act_q[0], {16'd0, 12'hF0F}); end
         if (act_q[1] !== {16'd1, 12'h0F0}) begin n_fail++; $display("FAIL basic_pix1: got %h expected %h", act_q[1], {16'd1, 12'h0F0}); end
      end
   endtask

   task automatic test_odd_line();
      clear_capture();
      frame_begin(1);
      send_line(rand_bytes(5), 1);
      send_line(rand_bytes(4), 1);
      frame_end();
      n_assert++;
      if (act_q.size() != 4) begin
         n_fail++; $display("FAIL odd_count: got %0d expected 4", act_q.size());
      end else foreach (exp_q[i]) begin
         n_assert++;
         if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL odd_write[%0d]: got %h expected %h", i, act_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 3; f++) begin
         clear_capture();
         frame_begin(1);
         for (int l = 0; l < int'($urandom_range(3, 5)); l++) send_line(rand_bytes(int'($urandom_range(0, 10))), 1);
         frame_end();
         n_assert += 2;
         if (done_cnt != 1) begin n_fail++; $display("FAIL rand_done[%0d]: got %0d expected 1", f, done_cnt); end
`ifdef CAPTURE_LINE_CNT_EN
         n_assert++;
         if (int'(LINE_CNT_O) != lines_exp) begin n_fail++; $display("FAIL rand_lines[%0d]: got %0d expected %0d", f, LINE_CNT_O, lines_exp); end
`endif
         if (act_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rand_count[%0d]: got %0d expected %0d", f, act_q.size(), exp_q.size());
         end else foreach (exp_q[i]) begin
            n_assert++;
            if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_write[%0d]: got %h expected %h", i, act_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      byte_q_t b;
      b = rand_bytes(6);
      clear_capture();
      frame_begin(1);
      for (int i = 0; i < b.size(); i++) begin
         @(negedge clk);
         CAM_HREF_I = 1'b1;
         CAM_DATA_I = b[i];
         if (i == b.size() - 1) CAM_VSYNC_I = 1'b1;
      end
      @(negedge clk) CAM_HREF_I = 1'b0;
      repeat (5) @(negedge clk);
      model_line(b);
      n_assert += 3;
      if (done_cnt != 1) begin n_fail++; $display("FAIL b2b_done: got %0d expected 1", done_cnt); end
      if (last_we_cyc != last_done_cyc) begin n_fail++; $display("FAIL b2b_same_cycle: got we@%0d done@%0d expected equal", last_we_cyc, last_done_cyc); end
      if (act_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL b2b_count: got %0d expected %0d", act_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         n_assert++;
         if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_write[%0d]: got %h expected %h", i, act_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_disable_midframe();
      clear_capture();
      frame_begin(1);
      send_line(rand_bytes(6), 1);
      ENABLE_I = 1'b0;
      send_line(rand_bytes(4), 1);
      frame_end();
      n_assert += 3;
      if (done_cnt != 1)   begin n_fail++; $display("FAIL dis_done: got %0d expected 1", done_cnt); end
      if (BUSY_O !== 1'b0) begin n_fail++; $display("FAIL dis_busy: got %b expected 0", BUSY_O); end
      if (act_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL dis_count: got %0d expected %0d", act_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         n_assert++;
         if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL dis_write[%0d]: got %h expected %h", i, act_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_midframe();
      byte_q_t b;
      b = rand_bytes(4);
      ENABLE_I = 1'b1;
      repeat (2) @(negedge clk);
      clear_capture();
      frame_begin(0);
      @(negedge clk) begin CAM_HREF_I = 1'b1; CAM_DATA_I = b[0]; end
      @(negedge clk) CAM_DATA_I = b[1];
      @(negedge clk) CAM_DATA_I = b[2];
      @(negedge clk) begin CAM_DATA_I = b[3]; RST_I = 1'b1; end
      @(negedge clk);
      n_assert += 5;
      if (BRAM_WE_O !== 1'b0)    begin n_fail++; $display("FAIL rstmid_we: got %b expected 0", BRAM_WE_O); end
      if (BRAM_ADDR_O !== 16'd0) begin n_fail++; $display("FAIL rstmid_addr: got %h expected 0", BRAM_ADDR_O); end
      if (BRAM_DATA_O !== 12'd0) begin n_fail++; $display("FAIL rstmid_data: got %h expected 0", BRAM_DATA_O); end
      if (FRAME_DONE_O !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0", FRAME_DONE_O); end
      if (BUSY_O !== 1'b0)       begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", BUSY_O); end
      CAM_HREF_I = 1'b0;
      repeat (2) @(negedge clk);
      RST_I = 1'b0;
      repeat (6) @(negedge clk);
      n_assert += 2;
      if (BUSY_O !== 1'b0) begin n_fail++; $display("FAIL rstmid_rearm: got %b expected 0", BUSY_O); end
      if (act_q.size() != 1) begin
         n_fail++; $display("FAIL rstmid_count: got %0d expected 1", act_q.size());
      end else begin
         n_assert++;
         if (act_q[0] !== {16'd0, pack_pix(b[0], b[1])}) begin
            n_fail++; $display("FAIL rstmid_pix0: got %h expected %h", act_q[0], {16'd0, pack_pix(b[0], b[1])});
         end
      end
   endtask

   task automatic test_full_frame();
      ENABLE_I = 1'b0;
      repeat (2) @(negedge clk);
      ENABLE_I = 1'b1;
      clear_capture();
      frame_begin(1);
      for (int l = 0; l < 97; l++) send_line(rand_bytes(640), 1);
      n_assert++;
      if (BRAM_ADDR_O !== 16'(MAX)) begin n_fail++; $display("FAIL full_addr_hold: got %0d expected %0d", BRAM_ADDR_O, MAX); end
      frame_end();
      n_assert += 3;
      if (done_cnt != 1) begin n_fail++; $display("FAIL full_done: got %0d expected 1", done_cnt); end
      if (BRAM_ADDR_O !== 16'(MAX)) begin n_fail++; $display("FAIL full_addr_end: got %0d expected %0d", BRAM_ADDR_O, MAX); end
      if (act_q.size() != MAX) begin
         n_fail++; $display("FAIL full_count: got %0d expected %0d", act_q.size(), MAX);
      end else begin
         n_assert++;
         if (act_q[MAX-1][27:12] !== 16'(MAX - 1)) begin n_fail++; $display("FAIL full_last_addr: got %0d expected %0d", act_q[MAX-1][27:12], MAX - 1); end
         foreach (exp_q[i]) begin
            n_assert++;
            if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_write[%0d]: got %h expected %h", i, act_q[i], exp_q[i]); end
         end
      end
   endtask

`ifdef CAPTURE_LINE_CNT_EN
   task automatic test_line_cnt();
      clear_capture();
      frame_begin(1);
      for (int l = 0; l < 3; l++) send_line(rand_bytes(4), 1);
      frame_end();
      n_assert++;
      if (LINE_CNT_O !== 10'd3) begin n_fail++; $display("FAIL linecnt_frame: got %0d expected 3", LINE_CNT_O); end
      CAM_VSYNC_I = 1'b0;
      repeat (4) @(negedge clk);
      n_assert++;
      if (LINE_CNT_O !== 10'd0) begin n_fail++; $display("FAIL linecnt_clear: got %0d expected 0", LINE_CNT_O); end
      frame_end();
   endtask
`endif

   initial begin
      test_reset();
      test_enable_held();
      test_basic();
      test_odd_line();
      test_random_frames();
      test_back_to_back();
      test_disable_midframe();
      test_reset_midframe();
      test_full_frame();
`ifdef CAPTURE_LINE_CNT_EN
      test_line_cnt();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
